wakeup_matrix: RTL and testbench
================================

Name: wakeup_matrix

Overview:
- Parametrised dependency-matrix scheduler with multiple dispatch write ports and multiple wakeup broadcast ports.
- Each wakeup carries a latency, so a producer's column clears N cycles after broadcast. This models multi-cycle functional units without external delay logic.
- Sits between rename/dispatch and the issue-select logic. Produces per-row valid and ready vectors.

Parameters:
- NUM_ROWS, 8, scheduler entries (consumers); power of two.
- NUM_COLS, 8, producer tags (dependency columns); power of two.
- W_PORTS, 2, dispatch write ports per cycle.
- C_PORTS, 2, wakeup broadcast ports per cycle.
- LAT_W, 2, width of wakeup latency field; max latency 2^LAT_W-1.

Ports:
- clk  in  1  clock; all state updates on rising edge.
- rst  in  1  asynchronous, active-low reset.
- w_en  in  W_PORTS  per-port dispatch write enable.
- w_row_index  in  W_PORTS x $clog2(NUM_ROWS)  row written by each port.
- set_lines  in  W_PORTS x NUM_COLS  dependency bits for the written row.
- clear_en  in  C_PORTS  per-port wakeup broadcast enable.
- clear_col  in  C_PORTS x $clog2(NUM_COLS)  producer column being woken.
- clear_lat  in  C_PORTS x LAT_W  cycles until the column clears (0 = this edge).
- free_en  in  1  release one row (issued or squashed).
- free_row_index  in  $clog2(NUM_ROWS)  row to release.
- flush  in  1  synchronous clear of all rows and pending wakeups.
- valid_vector  out  NUM_ROWS  row holds a live entry.
- ready_vector  out  NUM_ROWS  valid row with all dependency bits zero.
- pending_vector  out  NUM_COLS  column has a delayed wakeup in flight.
- err_conflict  out  1  one-cycle pulse: two enabled write ports targeted the same row.

Behaviour:
- Reset: while rst=0, asynchronously clear matrix, valid, pending flags, timers and err_conflict. All outputs read 0.
- State:
  - matrix[NUM_ROWS][NUM_COLS];
  - valid[NUM_ROWS];
  - per column, pend flag plus LAT_W-bit countdown cnt.
- Outputs:
  - ready_vector[r] = valid[r] & ~|matrix[r], combinational from registered state.
  - A row written at edge E with no surviving deps reads ready after E.
  - valid_vector and pending_vector are direct register outputs.
- Column clear event fire[c] is asserted in a cycle when either:
  - (a) some port has clear_en, clear_col=c and clear_lat=0; or
  - (b) pend[c]=1 and cnt[c]=0.
- When fire[c]: bit c is cleared in every row at the edge.
- Timer load: port with clear_en, clear_col=c, clear_lat=L>0 requests cnt=L-1, pend=1.
  - Result: the column clears exactly L edges after the sampling edge.
- Timer merge rules:
  - Multiple requests to one column in a cycle: the smallest latency wins. Any L=0 request fires immediately and cancels the load.
  - New request to an already-pending column: keep min(remaining cnt, L-1).
  - If that column also fires this cycle, the new request still loads.
- Timer run: pend=1 and cnt>0 decrements cnt each cycle. On fire via timer, pend clears unless reloaded that same cycle.
- Dispatch write: row w_row_index[p] gets valid=1 and matrix row = set_lines[p] & ~fire. This is the same-cycle wakeup bypass; no lost wakeups.
  - Bits for columns still pending (not firing) are set and clear later when the timer expires.
- Write-port conflict: lower-numbered port wins; err_conflict=1 for the following cycle only.
- Free: valid[free_row_index]=0 and the row's bits zeroed. Freeing an invalid row is a no-op.
- Write and free to the same row in one cycle: the write wins.
- Flush: at the edge, clears valid, matrix, pend and cnt. Takes priority over all same-cycle writes and clears. err_conflict is cleared.
- Overwriting an already-valid row is permitted; the new contents replace the old.
- Reset asserted mid-countdown discards all pending wakeups.

Decomposition:
- CORE_PKG gains constants SCHED_ROWS and SCHED_TAGS, and typedefs sched_row_idx_t, sched_col_idx_t, wake_lat_t.
- One sub-module, wakeup_delay_timer, instantiated per column.
  - Inputs: load requests.
  - Outputs: fire and pend.
  - Contains the min-merge and countdown logic.
- Matrix, valid and ready logic live in the top module.

Test Plan:
- Reset then write row 7 with deps 8'b01000010 via port 0, row 0 with 0 via port 1 in the same cycle -> next cycle valid=8'h81, ready=8'h01.
- Broadcast col 6 lat 0, then col 1 lat 2 -> row 7 bit 6 clears next cycle. pending_vector[1]=1 for 2 cycles. ready[7] rises exactly 2 edges after the col-1 broadcast.
- Write row 3 with deps col 2 in the same cycle col 2 fires with lat 0 -> row 3 ready immediately after the edge. Repeat with col 2 pending (lat 3) -> row 3 waits for timer expiry.
- Two ports clear col 4 with lat 3 and lat 1 in one cycle -> col 4 clears 1 edge later. A later lat-3 request while cnt=0 does not delay the clear.
- Both write ports target row 5 -> port 0 contents stored, err_conflict pulses for 1 cycle. Free row 5 while writing row 5 -> row stays valid with new deps.
- Load several timers, assert flush -> all vectors 0 next cycle, no column fires later. Assert rst=0 asynchronously mid-countdown -> outputs 0 immediately.

Source files
------------

// File: rtl/wakeup_matrix_pkg.sv
// Shared sizing constants and index/latency types for the wakeup dependency matrix.
package wakeup_matrix_pkg;

    localparam int SCHED_ROWS   = 8;
    localparam int SCHED_TAGS   = 8;
    localparam int SCHED_WPORTS = 2;
    localparam int SCHED_CPORTS = 2;
    localparam int WAKE_LAT_W   = 2;

    typedef logic [$clog2(SCHED_ROWS)-1:0] sched_row_idx_t;
    typedef logic [$clog2(SCHED_TAGS)-1:0] sched_col_idx_t;
    typedef logic [WAKE_LAT_W-1:0]         wake_lat_t;

endpackage

// File: rtl/wakeup_delay_timer.sv
// Per-column delayed-wakeup timer: merges same-cycle requests to the earliest
// latency and counts down to a one-cycle column clear.
module wakeup_delay_timer
    import wakeup_matrix_pkg::*;
#(
    parameter int C_PORTS = SCHED_CPORTS,
    parameter int LAT_W   = WAKE_LAT_W
) (
    input  logic                            clk,
    input  logic                            rst,
    input  logic                            i_flush,
    input  logic [C_PORTS-1:0]              i_req_vld,
    input  logic [C_PORTS-1:0][LAT_W-1:0]   i_req_lat,
    output logic                            o_fire,
    output logic                            o_pend
);

    logic             r_pend;
    logic [LAT_W-1:0] r_cnt;
    logic             w_imm;
    logic             w_load;
    logic             w_timer_fire;
    logic [LAT_W-1:0] w_req_min;
    logic [LAT_W-1:0] w_next_cnt;

    always_comb begin
        w_imm     = 1'b0;
        w_load    = 1'b0;
        w_req_min = '1;
        for (int p = 0; p < C_PORTS; p++) begin
            if (i_req_vld[p]) begin
                if (i_req_lat[p] == '0) begin
                    w_imm = 1'b1;
                end else begin
                    w_load = 1'b1;
                    if ((i_req_lat[p] - LAT_W'(1)) < w_req_min)
                        w_req_min = i_req_lat[p] - LAT_W'(1);
                end
            end
        end
        w_timer_fire = r_pend && (r_cnt == '0);
        // A running countdown that is not expiring this cycle competes with
        // the new request using its post-decrement value, so neither is delayed.
        w_next_cnt = w_req_min;
        if (r_pend && !w_timer_fire && ((r_cnt - LAT_W'(1)) < w_req_min))
            w_next_cnt = r_cnt - LAT_W'(1);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_pend <= 1'b0;
            r_cnt  <= '0;
        end else if (i_flush) begin
            r_pend <= 1'b0;
            r_cnt  <= '0;
        end else if (w_load && !w_imm) begin
            r_pend <= 1'b1;
            r_cnt  <= w_next_cnt;
        end else if (w_timer_fire) begin
            r_pend <= 1'b0;
        end else if (r_pend) begin
            r_cnt <= r_cnt - LAT_W'(1);
        end
    end

    assign o_fire = w_imm | w_timer_fire;
    assign o_pend = r_pend;

endmodule

// File: rtl/wakeup_matrix.sv
// Dependency-matrix scheduler: dispatch writes set per-row producer bits,
// immediate or delayed wakeups clear columns, ready = valid row with no deps.
module wakeup_matrix
    import wakeup_matrix_pkg::*;
#(
    parameter int NUM_ROWS = SCHED_ROWS,
    parameter int NUM_COLS = SCHED_TAGS,
    parameter int W_PORTS  = SCHED_WPORTS,
    parameter int C_PORTS  = SCHED_CPORTS,
    parameter int LAT_W    = WAKE_LAT_W,
    localparam int RW      = $clog2(NUM_ROWS),
    localparam int CW      = $clog2(NUM_COLS)
) (
    input  logic                                clk,
    input  logic                                rst,
    input  logic [W_PORTS-1:0]                  w_en,
    input  logic [W_PORTS-1:0][RW-1:0]          w_row_index,
    input  logic [W_PORTS-1:0][NUM_COLS-1:0]    set_lines,
    input  logic [C_PORTS-1:0]                  clear_en,
    input  logic [C_PORTS-1:0][CW-1:0]          clear_col,
    input  logic [C_PORTS-1:0][LAT_W-1:0]       clear_lat,
    input  logic                                free_en,
    input  logic [RW-1:0]                       free_row_index,
    input  logic                                flush,
    output logic [NUM_ROWS-1:0]                 valid_vector,
    output logic [NUM_ROWS-1:0]                 ready_vector,
    output logic [NUM_COLS-1:0]                 pending_vector,
    output logic                                err_conflict
);

    logic [NUM_ROWS-1:0][NUM_COLS-1:0] r_matrix;
    logic [NUM_ROWS-1:0]               r_valid;
    logic                              r_err;

    logic [NUM_COLS-1:0]               w_fire;
    logic [NUM_COLS-1:0]               w_pend;
    logic [NUM_ROWS-1:0]               w_wr_hit;
    logic [NUM_ROWS-1:0][NUM_COLS-1:0] w_wr_data;
    logic                              w_conflict;

    for (genvar c = 0; c < NUM_COLS; c++) begin : g_col
        logic [C_PORTS-1:0] w_req;

        always_comb begin
            w_req = '0;
            for (int p = 0; p < C_PORTS; p++)
                w_req[p] = clear_en[p] && (clear_col[p] == CW'(c));
        end

        wakeup_delay_timer #(
            .C_PORTS (C_PORTS),
            .LAT_W   (LAT_W)
        ) u_timer (
            .clk       (clk),
            .rst       (rst),
            .i_flush   (flush),
            .i_req_vld (w_req),
            .i_req_lat (clear_lat),
            .o_fire    (w_fire[c]),
            .o_pend    (w_pend[c])
        );
    end

    // Highest port visited first so the lowest-numbered port's data survives.
    always_comb begin
        w_wr_hit   = '0;
        w_wr_data  = '0;
        w_conflict = 1'b0;
        for (int p = W_PORTS - 1; p >= 0; p--) begin
            if (w_en[p]) begin
                w_wr_hit[w_row_index[p]]  = 1'b1;
                w_wr_data[w_row_index[p]] = set_lines[p];
            end
        end
        for (int p = 0; p < W_PORTS; p++)
            for (int q = p + 1; q < W_PORTS; q++)
                if (w_en[p] && w_en[q] && (w_row_index[p] == w_row_index[q]))
                    w_conflict = 1'b1;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_matrix <= '0;
            r_valid  <= '0;
            r_err    <= 1'b0;
        end else if (flush) begin
            r_matrix <= '0;
            r_valid  <= '0;
            r_err    <= 1'b0;
        end else begin
            r_err <= w_conflict;
            for (int r = 0; r < NUM_ROWS; r++) begin
                if (w_wr_hit[r]) begin
                    r_valid[r]  <= 1'b1;
                    r_matrix[r] <= w_wr_data[r] & ~w_fire;
                end else if (free_en && (free_row_index == RW'(r))) begin
                    r_valid[r]  <= 1'b0;
                    r_matrix[r] <= '0;
                end else begin
                    r_matrix[r] <= r_matrix[r] & ~w_fire;
                end
            end
        end
    end

    always_comb begin
        ready_vector = '0;
        for (int r = 0; r < NUM_ROWS; r++)
            ready_vector[r] = r_valid[r] & ~(|r_matrix[r]);
    end

    assign valid_vector   = r_valid;
    assign pending_vector = w_pend;
    assign err_conflict   = r_err;

endmodule

// File: tb/tb_wakeup_matrix.sv
// Directed bench for wakeup_matrix: expected vectors are queued with each
// stimulus step and popped for comparison one edge later.
module tb_wakeup_matrix;
    import wakeup_matrix_pkg::*;

    logic                         clk;
    logic                         rst;
    logic [1:0]                   w_en;
    logic [1:0][2:0]              w_row_index;
    logic [1:0][7:0]              set_lines;
    logic [1:0]                   clear_en;
    logic [1:0][2:0]              clear_col;
    logic [1:0][1:0]              clear_lat;
    logic                         free_en;
    logic [2:0]                   free_row_index;
    logic                         flush;
    logic [7:0]                   valid_vector;
    logic [7:0]                   ready_vector;
    logic [7:0]                   pending_vector;
    logic                         err_conflict;

    typedef struct {
        string      tag;
        logic [7:0] v;
        logic [7:0] r;
        logic [7:0] p;
        logic       e;
    } exp_t;

    exp_t q[$];
    int   checks   = 0;
    int   failures = 0;

    wakeup_matrix dut (
        .clk            (clk),
        .rst            (rst),
        .w_en           (w_en),
        .w_row_index    (w_row_index),
        .set_lines      (set_lines),
        .clear_en       (clear_en),
        .clear_col      (clear_col),
        .clear_lat      (clear_lat),
        .free_en        (free_en),
        .free_row_index (free_row_index),
        .flush          (flush),
        .valid_vector   (valid_vector),
        .ready_vector   (ready_vector),
        .pending_vector (pending_vector),
        .err_conflict   (err_conflict)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #100000;
        $display("FAIL watchdog expired checks=%0d", checks);
        $fatal(1, "watchdog");
    end

    task automatic idle_inputs();
        w_en           = '0;
        w_row_index    = '0;
        set_lines      = '0;
        clear_en       = '0;
        clear_col      = '0;
        clear_lat      = '0;
        free_en        = 1'b0;
        free_row_index = '0;
        flush          = 1'b0;
    endtask

    task automatic wr(input int port, input int row, input logic [7:0] deps);
        w_en[port]        = 1'b1;
        w_row_index[port] = sched_row_idx_t'(row);
        set_lines[port]   = deps;
    endtask

    task automatic clr(input int port, input int col, input int lat);
        clear_en[port]  = 1'b1;
        clear_col[port] = sched_col_idx_t'(col);
        clear_lat[port] = wake_lat_t'(lat);
    endtask

    task automatic fre(input int row);
        free_en        = 1'b1;
        free_row_index = sched_row_idx_t'(row);
    endtask

    task automatic cmp8(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic cmp_all(input string tag, input logic [7:0] v, input logic [7:0] r,
                           input logic [7:0] p, input logic e);
        cmp8({tag, ".valid"}, valid_vector, v);
        cmp8({tag, ".ready"}, ready_vector, r);
        cmp8({tag, ".pend"}, pending_vector, p);
        cmp8({tag, ".err"}, {7'd0, err_conflict}, {7'd0, e});
    endtask

    task automatic push_exp(input string tag, input logic [7:0] v, input logic [7:0] r,
                            input logic [7:0] p, input logic e);
        exp_t x;
        x.tag = tag;
        x.v   = v;
        x.r   = r;
        x.p   = p;
        x.e   = e;
        q.push_back(x);
    endtask

    task automatic tick_and_check();
        exp_t x;
        @(posedge clk);
        #1;
        checks++;
        assert (q.size() > 0) else begin
            failures++;
            $error("FAIL scoreboard_empty observed=0 expected=1");
        end
        if (q.size() > 0) begin
            x = q.pop_front();
            cmp_all(x.tag, x.v, x.r, x.p, x.e);
        end
        idle_inputs();
    endtask

    initial begin
        rst = 1'b0;
        idle_inputs();
        #12;
        cmp_all("reset", 8'h00, 8'h00, 8'h00, 1'b0);
        @(negedge clk);
        rst = 1'b1;

        wr(0, 7, 8'b0100_0010); wr(1, 0, 8'h00);
        push_exp("dual_write", 8'h81, 8'h01, 8'h00, 1'b0); tick_and_check();

        clr(0, 6, 0);
        push_exp("clr6_lat0", 8'h81, 8'h01, 8'h00, 1'b0); tick_and_check();

        clr(1, 1, 2);
        push_exp("clr1_lat2_e0", 8'h81, 8'h01, 8'h02, 1'b0); tick_and_check();
        push_exp("clr1_lat2_e1", 8'h81, 8'h01, 8'h02, 1'b0); tick_and_check();
        push_exp("clr1_lat2_e2", 8'h81, 8'h81, 8'h00, 1'b0); tick_and_check();

        wr(0, 3, 8'h04); clr(0, 2, 0);
        push_exp("bypass_fire", 8'h89, 8'h89, 8'h00, 1'b0); tick_and_check();

        clr(0, 2, 3); fre(3);
        push_exp("free3_load2", 8'h81, 8'h81, 8'h04, 1'b0); tick_and_check();
        wr(1, 3, 8'h04);
        push_exp("write_pending", 8'h89, 8'h81, 8'h04, 1'b0); tick_and_check();
        push_exp("pending_wait", 8'h89, 8'h81, 8'h04, 1'b0); tick_and_check();
        push_exp("pending_expire", 8'h89, 8'h89, 8'h00, 1'b0); tick_and_check();

        wr(0, 1, 8'h10); clr(0, 4, 3); clr(1, 4, 1);
        push_exp("min_merge", 8'h8b, 8'h89, 8'h10, 1'b0); tick_and_check();
        clr(0, 4, 3);
        push_exp("reload_on_fire", 8'h8b, 8'h8b, 8'h10, 1'b0); tick_and_check();
        push_exp("reload_run1", 8'h8b, 8'h8b, 8'h10, 1'b0); tick_and_check();
        push_exp("reload_run2", 8'h8b, 8'h8b, 8'h10, 1'b0); tick_and_check();
        push_exp("reload_done", 8'h8b, 8'h8b, 8'h00, 1'b0); tick_and_check();

        wr(0, 5, 8'h20); wr(1, 5, 8'h00);
        push_exp("conflict", 8'hab, 8'h8b, 8'h00, 1'b1); tick_and_check();
        push_exp("conflict_pulse_end", 8'hab, 8'h8b, 8'h00, 1'b0); tick_and_check();
        wr(1, 5, 8'h00); fre(5);
        push_exp("write_beats_free", 8'hab, 8'hab, 8'h00, 1'b0); tick_and_check();

        clr(0, 0, 3); clr(1, 7, 2); wr(0, 2, 8'h81);
        push_exp("preflush", 8'haf, 8'hab, 8'h81, 1'b0); tick_and_check();
        flush = 1'b1; wr(0, 4, 8'h01); wr(1, 4, 8'h02); clr(0, 3, 2);
        push_exp("flush", 8'h00, 8'h00, 8'h00, 1'b0); tick_and_check();
        wr(0, 6, 8'h01);
        push_exp("postflush_w", 8'h40, 8'h00, 8'h00, 1'b0); tick_and_check();
        push_exp("postflush_1", 8'h40, 8'h00, 8'h00, 1'b0); tick_and_check();
        push_exp("postflush_2", 8'h40, 8'h00, 8'h00, 1'b0); tick_and_check();

        clr(0, 5, 3); wr(0, 2, 8'h20);
        push_exp("prereset", 8'h44, 8'h00, 8'h20, 1'b0); tick_and_check();
        #3;
        rst = 1'b0;
        #1;
        cmp_all("async_reset", 8'h00, 8'h00, 8'h00, 1'b0);
        @(negedge clk);
        rst = 1'b1;
        push_exp("postreset_1", 8'h00, 8'h00, 8'h00, 1'b0); tick_and_check();
        push_exp("postreset_2", 8'h00, 8'h00, 8'h00, 1'b0); tick_and_check();
        push_exp("postreset_3", 8'h00, 8'h00, 8'h00, 1'b0); tick_and_check();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
